// File: rtl/uart_responder.sv
// 8N1 UART slave on low-active rdn/wrn strobes: THR -> txd serialiser, rxd -> RBR deserialiser.
// Define UART_LOOPBACK_EN to feed the RX path from the internal TX stream (txd pin held high, rxd ignored).
module uart_responder #(
  parameter int CLK_HZ = 11_059_200,
  parameter int BAUD   = 115_200
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rdn,
  input  logic       wrn,
  inout  wire  [7:0] bus_data,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd
);

  // DIV must be >= 1; 16 ticks per bit time.
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tick;
  logic          rdn_q, wrn_q;
  logic          wr_fire, rd_rise;

  state_t        tx_st_q, tx_st_d;
  logic [7:0]    thr_q, thr_d, tx_sh_q, tx_sh_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          txd_q, txd_d, tbre_q, tbre_d, tsre_q, tsre_d;

  state_t        rx_st_q, rx_st_d;
  logic [1:0]    rx_sync_q;
  logic          rx_prev_q, rx_s, rx_src;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d, rbr_q, rbr_d;
  logic          dr_q, dr_d;

  assign tick    = (tcnt_q == CW'(DIV - 1));
  assign tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
  // A simultaneous read suppresses the write.
  assign wr_fire = wrn_q & ~wrn & rdn;
  assign rd_rise = ~rdn_q & rdn;
  assign rx_s    = rx_sync_q[1];

`ifdef UART_LOOPBACK_EN
  assign rx_src = txd_q;
  assign txd    = 1'b1;
`else
  assign rx_src = rxd;
  assign txd    = txd_q;
`endif

  assign bus_data   = (!rdn && !Rst) ? rbr_q : 8'hzz;
  assign data_ready = dr_q;
  assign tbre       = tbre_q;
  assign tsre       = tsre_q;

  always_comb begin
    tx_st_d  = tx_st_q;
    thr_d    = thr_q;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    txd_d    = txd_q;
    tbre_d   = tbre_q;
    tsre_d   = tsre_q;

    if (wr_fire && tbre_q) begin
      thr_d  = bus_data;
      tbre_d = 1'b0;
    end

    case (tx_st_q)
      S_IDLE: begin
        if (tick && !tbre_q) begin
          tx_sh_d  = thr_q;
          tbre_d   = 1'b1;
          tsre_d   = 1'b0;
          txd_d    = 1'b0;
          tx_cnt_d = 4'd0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (tx_cnt_q == 4'd15) begin
            tx_cnt_d = 4'd0;
            tx_bit_d = 3'd0;
            txd_d    = tx_sh_q[0];
            tx_st_d  = S_DATA;
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tx_cnt_q == 4'd15) begin
            tx_cnt_d = 4'd0;
            if (tx_bit_q == 3'd7) begin
              txd_d   = 1'b1;
              tx_st_d = S_STOP;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
              txd_d    = tx_sh_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tx_cnt_q == 4'd15) begin
            tx_cnt_d = 4'd0;
            // A pending byte starts immediately, with no idle bit in between.
            if (!tbre_q) begin
              tx_sh_d = thr_q;
              tbre_d  = 1'b1;
              txd_d   = 1'b0;
              tx_st_d = S_START;
            end else begin
              tsre_d  = 1'b1;
              tx_st_d = S_IDLE;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rbr_d    = rbr_q;
    dr_d     = dr_q;

    if (rd_rise) dr_d = 1'b0;

    case (rx_st_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_cnt_d = 4'd0;
          rx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          // Mid-start resample rejects short glitches.
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d = 4'd0;
            rx_bit_d = 3'd0;
            rx_st_d  = rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d = 4'd0;
            rx_sh_d  = {rx_s, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
            else                  rx_bit_d = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_cnt_q == 4'd15) begin
            if (rx_s) begin
              rbr_d = rx_sh_q;
              dr_d  = 1'b1;
            end
            rx_st_d = S_IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tcnt_q    <= '0;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      tx_st_q   <= S_IDLE;
      thr_q     <= 8'h00;
      tx_sh_q   <= 8'h00;
      tx_cnt_q  <= 4'd0;
      tx_bit_q  <= 3'd0;
      txd_q     <= 1'b1;
      tbre_q    <= 1'b1;
      tsre_q    <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_cnt_q  <= 4'd0;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
      rbr_q     <= 8'h00;
      dr_q      <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      rdn_q     <= rdn;
      wrn_q     <= wrn;
      tx_st_q   <= tx_st_d;
      thr_q     <= thr_d;
      tx_sh_q   <= tx_sh_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      txd_q     <= txd_d;
      tbre_q    <= tbre_d;
      tsre_q    <= tsre_d;
      rx_st_q   <= rx_st_d;
      rx_sync_q <= {rx_sync_q[0], rx_src};
      rx_prev_q <= rx_s;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rbr_q     <= rbr_d;
      dr_q      <= dr_d;
    end
  end

endmodule

// File: tb/tb_uart_responder.sv
// Bench for uart_responder at DIV=1 (16 cycles per bit); TX and read data checked by scoreboard monitors.
module tb_uart_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic       bus_oe = 1'b0;
  logic [7:0] bus_dat = 8'h00;
  wire  [7:0] bus_data;
  logic       data_ready, tbre, tsre, txd;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];

  assign bus_data = bus_oe ? bus_dat : 8'hzz;
  always #5 clk = ~clk;

  uart_responder #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .Clk(clk), .Rst(rst), .rdn(rdn), .wrn(wrn), .bus_data(bus_data),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX monitor: decode frames on txd at mid-bit, compare against expected queue.
  int         m_cnt = 0;
  logic       m_busy = 1'b0;
  logic       m_prev = 1'b1;
  logic [7:0] m_byte = 8'h00;
  logic       txd_low_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!txd) txd_low_seen = 1'b1;
    if (rst) begin
      m_busy = 1'b0;
      m_prev = 1'b1;
    end else if (!m_busy) begin
      if (m_prev && !txd) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
      m_prev = txd;
    end else begin
      m_cnt++;
      if (m_cnt == 8) begin
        chk("tx_start_bit", {31'd0, txd}, 32'd0);
      end else if (m_cnt >= 24 && m_cnt <= 136 && ((m_cnt - 24) % 16) == 0) begin
        m_byte[(m_cnt - 24) / 16] = txd;
      end else if (m_cnt == 152) begin
        chk("tx_stop_bit", {31'd0, txd}, 32'd1);
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected_frame: got %0h expected none", m_byte);
        end else begin
          chk("tx_byte", {24'd0, m_byte}, {24'd0, exp_tx.pop_front()});
        end
        m_busy = 1'b0;
        m_prev = txd;
      end
    end
  end

  // Read monitor: compare bus_data on the first cycle rdn is low.
  logic r_prev = 1'b1;
  always @(posedge clk) begin
    #1;
    if (r_prev && !rdn) begin
      if (exp_rd.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h expected none", bus_data);
      end else begin
        chk("rd_data", {24'd0, bus_data}, {24'd0, exp_rd.pop_front()});
      end
    end
    r_prev = rdn;
  end

  task automatic wr(input logic [7:0] b, input bit push);
    @(negedge clk);
    bus_dat = b;
    bus_oe  = 1'b1;
    wrn     = 1'b0;
    if (push) exp_tx.push_back(b);
    @(negedge clk);
    wrn    = 1'b1;
    bus_oe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] b);
    exp_rd.push_back(b);
    @(negedge clk);
    rdn = 1'b0;
    @(negedge clk);
    rdn = 1'b1;
  endtask

  task automatic wait_tsre(input string name, input int exp_n);
    int n = 0;
    while (tsre !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_n);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic tx_one(input logic [7:0] b);
    wr(b, 1'b1);
    chk("tbre_after_write", {31'd0, tbre}, 32'd0);
    @(negedge clk);
    chk("tbre_at_frame_start", {31'd0, tbre}, 32'd1);
    chk("tsre_at_frame_start", {31'd0, tsre}, 32'd0);
    wait_tsre("tx_frame_cycles", 160);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_tbre", {31'd0, tbre}, 32'd1);
    chk("rst_tsre", {31'd0, tsre}, 32'd1);
    chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifdef UART_LOOPBACK_EN
    begin
      int n = 0;
      wr(8'hC3, 1'b0);
      while (data_ready !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("lb_data_ready", {31'd0, data_ready}, 32'd1);
      rd(8'hC3);
      @(negedge clk);
      chk("lb_data_ready_clear", {31'd0, data_ready}, 32'd0);
      chk("lb_txd_pin_low_seen", {31'd0, txd_low_seen}, 32'd0);
    end
`else
    // Single frame
    tx_one(8'hA5);

    // Back-to-back frames; third write lands while THR is full and is lost
    wr(8'h3C, 1'b1);
    @(negedge clk);
    chk("b2b_tbre_reload", {31'd0, tbre}, 32'd1);
    wr(8'hFF, 1'b1);
    chk("b2b_tbre_full", {31'd0, tbre}, 32'd0);
    wr(8'h77, 1'b0);
    wait_tsre("b2b_two_frame_cycles", 316);
    chk("b2b_tbre_end", {31'd0, tbre}, 32'd1);
    chk("b2b_tx_queue_drained", exp_tx.size(), 32'd0);

    // Receive 5A then read it back
    send_rx(8'h5A, 1'b1);
    chk("rx_5a_data_ready", {31'd0, data_ready}, 32'd1);
    rd(8'h5A);
    chk("dr_held_until_rise", {31'd0, data_ready}, 32'd1);
    @(negedge clk);
    chk("dr_cleared_on_rise", {31'd0, data_ready}, 32'd0);

    // Glitch rejection
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_byte", {31'd0, data_ready}, 32'd0);

    // Framing error
    send_rx(8'hE7, 1'b0);
    repeat (20) @(negedge clk);
    chk("framing_no_byte", {31'd0, data_ready}, 32'd0);

    // Overrun: second byte overwrites the unread first
    send_rx(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    send_rx(8'h22, 1'b1);
    chk("overrun_data_ready", {31'd0, data_ready}, 32'd1);
    rd(8'h22);
    @(negedge clk);

    // Read and write strobes together: read wins, write ignored
    exp_rd.push_back(8'h22);
    @(negedge clk);
    rdn = 1'b0;
    wrn = 1'b0;
    @(negedge clk);
    rdn = 1'b1;
    wrn = 1'b1;
    repeat (3) @(negedge clk);
    chk("both_strobes_tbre", {31'd0, tbre}, 32'd1);

    // Reset mid-frame
    wr(8'h96, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_tbre", {31'd0, tbre}, 32'd1);
    chk("midrst_tsre", {31'd0, tsre}, 32'd1);
    chk("midrst_data_ready", {31'd0, data_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tx_one(8'h81);
`endif

    repeat (20) @(negedge clk);
    chk("final_tx_queue_empty", exp_tx.size(), 32'd0);
    chk("final_rd_queue_empty", exp_rd.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
